// File: rtl/computer_pkg.sv
// Shared types and helpers for the computer network node endpoint.
// Contents: FSM state enum, {id,value} word field positions, and
// pack/unpack helpers for the 32-bit packet format used on every port.
package computer_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RECV,
    S_ANNOUNCE,
    S_SEND
  } state_e;

  localparam int unsigned ID_HI  = 31;
  localparam int unsigned ID_LO  = 16;
  localparam int unsigned VAL_HI = 15;
  localparam int unsigned VAL_LO = 0;

  function automatic logic [31:0] pack_word(input logic [15:0] id, input logic [15:0] val);
    return {id, val};
  endfunction

  function automatic logic [15:0] word_id(input logic [31:0] w);
    return w[ID_HI:ID_LO];
  endfunction

  function automatic logic [15:0] word_val(input logic [31:0] w);
    return w[VAL_HI:VAL_LO];
  endfunction

endpackage

// File: rtl/computer_rx_buffer.sv
// Receive buffer: DEPTH x 16 register file, synchronous write at the
// internal write pointer, asynchronous read at rd_addr.
// Ports:
//   clk, rst  - clock, synchronous active-high reset (clears pointer only)
//   clr       - clear the write pointer at the end of a burst
//   we, wdata - write wdata at the current pointer and advance it
//   rd_addr   - read address (driven by the transmit counter)
//   rd_data   - word at rd_addr
//   wr_cnt    - number of words written since the last clear
module computer_rx_buffer
  import computer_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          we,
  input  logic [15:0]   wdata,
  input  logic [AW-1:0] rd_addr,
  output logic [15:0]   rd_data,
  output logic [CW-1:0] wr_cnt
);

  logic [15:0] mem [DEPTH];

  // Write pointer; one extra bit so a full buffer (DEPTH words) is representable.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_cnt <= '0;
    end else if (we) begin
      wr_cnt <= wr_cnt + CW'(1);
    end
  end

  // Storage carries no reset; contents are only read after being written.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_cnt[AW-1:0]] <= wdata;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/computer.sv
// Network node endpoint: accepts a burst announcement, captures the burst
// from the announced sender, then re-announces and re-transmits it under
// this node's id with each payload offset by node_id (mod 2^16).
// Optional feature macro: COMPUTER_CHECKSUM_EN - announce length+1 and
// append one word carrying the XOR of all transformed payloads.
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   node_id, max_node  - this node's id and network size (static)
//   control_rx_packet  - {sender, length} burst announcement, 0 = idle
//   control_tx_packet  - {node_id, length} one-cycle announce, registered
//   data_rx_node_id    - sender of the burst being received, registered
//   data_rx_packet     - {sender, payload}, sender 0 = no word
//   data_tx_packet     - {node_id, transformed payload}, registered
module computer
  import computer_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] node_id,
  input  logic [15:0] max_node,
  input  logic [31:0] control_rx_packet,
  output logic [31:0] control_tx_packet,
  output logic [15:0] data_rx_node_id,
  input  logic [31:0] data_rx_packet,
  output logic [31:0] data_tx_packet
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  state_e        state_q, state_d;
  logic [15:0]   sender_q, sender_d;
  logic [15:0]   len_q, len_d;
  logic [CW-1:0] rd_cnt_q, rd_cnt_d;
  logic [15:0]   csum_q, csum_d;
  logic [31:0]   ctrl_tx_d;
  logic [15:0]   rx_id_d;
  logic [31:0]   data_tx_d;

  logic          buf_we_c;
  logic          buf_clr_c;
  logic [15:0]   buf_rd_data;
  logic [CW-1:0] buf_wr_cnt;

  logic          node_ok_c;
  logic          ctrl_ok_c;
  logic          data_hit_c;
  logic          last_c;
  logic          csum_word_c;
  logic [15:0]   xformed_c;
  logic [15:0]   ann_len_c;

  computer_rx_buffer #(.DEPTH(DEPTH)) u_rx_buffer (
    .clk     (clk),
    .rst     (rst),
    .clr     (buf_clr_c),
    .we      (buf_we_c),
    .wdata   (word_val(data_rx_packet)),
    .rd_addr (rd_cnt_q[AW-1:0]),
    .rd_data (buf_rd_data),
    .wr_cnt  (buf_wr_cnt)
  );

  // Acceptance and transmit-side qualifiers.
  always_comb begin
    node_ok_c  = (node_id != 16'd0) && (node_id <= max_node);
    ctrl_ok_c  = node_ok_c
                 && (word_id(control_rx_packet) != 16'd0)
                 && (word_val(control_rx_packet) != 16'd0)
                 && (word_val(control_rx_packet) <= 16'(DEPTH));
    data_hit_c = (word_id(data_rx_packet) == sender_q);
    xformed_c  = buf_rd_data + node_id;
`ifdef COMPUTER_CHECKSUM_EN
    ann_len_c   = len_q + 16'd1;
    csum_word_c = (16'(rd_cnt_q) == len_q);
    last_c      = (16'(rd_cnt_q) == len_q + 16'd1);
`else
    ann_len_c   = len_q;
    csum_word_c = 1'b0;
    last_c      = (16'(rd_cnt_q) == len_q);
`endif
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    sender_d  = sender_q;
    len_d     = len_q;
    rd_cnt_d  = rd_cnt_q;
    csum_d    = csum_q;
    ctrl_tx_d = '0;
    rx_id_d   = data_rx_node_id;
    data_tx_d = data_tx_packet;
    buf_we_c  = 1'b0;
    buf_clr_c = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        data_tx_d = '0;
        if (ctrl_ok_c) begin
          sender_d = word_id(control_rx_packet);
          len_d    = word_val(control_rx_packet);
          rx_id_d  = word_id(control_rx_packet);
          state_d  = S_RECV;
        end
      end

      S_RECV: begin
        if (data_hit_c) begin
          buf_we_c = 1'b1;
          // This edge captures the final word, so announce immediately.
          if (16'(buf_wr_cnt) + 16'd1 == len_q) begin
            rx_id_d   = '0;
            ctrl_tx_d = pack_word(node_id, ann_len_c);
            state_d   = S_ANNOUNCE;
          end
        end
      end

      S_ANNOUNCE: begin
        // rd_cnt_q is 0 here, so the buffer presents word 0.
        data_tx_d = pack_word(node_id, xformed_c);
        csum_d    = xformed_c;
        rd_cnt_d  = CW'(1);
        state_d   = S_SEND;
      end

      S_SEND: begin
        if (last_c) begin
          data_tx_d = '0;
          rd_cnt_d  = '0;
          csum_d    = '0;
          buf_clr_c = 1'b1;
          state_d   = S_IDLE;
          // Back-to-back acceptance on the edge that re-enters IDLE.
          if (ctrl_ok_c) begin
            sender_d = word_id(control_rx_packet);
            len_d    = word_val(control_rx_packet);
            rx_id_d  = word_id(control_rx_packet);
            state_d  = S_RECV;
          end
        end else if (csum_word_c) begin
          data_tx_d = pack_word(node_id, csum_q);
          rd_cnt_d  = rd_cnt_q + CW'(1);
        end else begin
          data_tx_d = pack_word(node_id, xformed_c);
          csum_d    = csum_q ^ xformed_c;
          rd_cnt_d  = rd_cnt_q + CW'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= S_IDLE;
      sender_q          <= '0;
      len_q             <= '0;
      rd_cnt_q          <= '0;
      csum_q            <= '0;
      control_tx_packet <= '0;
      data_rx_node_id   <= '0;
      data_tx_packet    <= '0;
    end else begin
      state_q           <= state_d;
      sender_q          <= sender_d;
      len_q             <= len_d;
      rd_cnt_q          <= rd_cnt_d;
      csum_q            <= csum_d;
      control_tx_packet <= ctrl_tx_d;
      data_rx_node_id   <= rx_id_d;
      data_tx_packet    <= data_tx_d;
    end
  end

endmodule

// File: tb/tb_computer.sv
// Self-checking bench for computer: directed plan scenarios plus random
// bursts, checked against a burst-level reference model (expected announce
// and output stream computed directly from the payload list).
module tb_computer;

  localparam int unsigned DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] node_id;
  logic [15:0] max_node;
  logic [31:0] control_rx_packet;
  logic [31:0] control_tx_packet;
  logic [15:0] data_rx_node_id;
  logic [31:0] data_rx_packet;
  logic [31:0] data_tx_packet;

  int vectors = 0;
  int miscompares = 0;
  logic [15:0] pay[$];

  computer #(.DEPTH(DEPTH)) dut (
    .clk               (clk),
    .rst               (rst),
    .node_id           (node_id),
    .max_node          (max_node),
    .control_rx_packet (control_rx_packet),
    .control_tx_packet (control_tx_packet),
    .data_rx_node_id   (data_rx_node_id),
    .data_rx_packet    (data_rx_packet),
    .data_tx_packet    (data_tx_packet)
  );

  always #5 clk = ~clk;

  // Advance one edge; outputs are then stable and inputs may change.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [15:0] nid, input logic [15:0] mx);
    node_id = nid;
    max_node = mx;
    control_rx_packet = '0;
    data_rx_packet = '0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // Full burst: announce in, words in (optionally with foreign words and
  // stray control packets interleaved), then check announce and output stream.
  task automatic run_burst(input logic [15:0] snd, input bit noisy, input string tag);
    int n;
    logic [15:0] exp_len, t, x;
    n = pay.size();
`ifdef COMPUTER_CHECKSUM_EN
    exp_len = 16'(n + 1);
`else
    exp_len = 16'(n);
`endif
    control_rx_packet = {snd, 16'(n)};
    step();
    control_rx_packet = '0;
    vectors++;
    if (data_rx_node_id !== snd) begin
      miscompares++;
      $display("FAIL %s accept: data_rx_node_id=%h expected %h", tag, data_rx_node_id, snd);
    end
    for (int i = 0; i < n; i++) begin
      if (noisy && ($urandom_range(0, 1) == 1)) begin
        data_rx_packet = {($urandom_range(0, 1) == 1) ? 16'h0000 : (snd ^ 16'h8000), 16'($urandom)};
        control_rx_packet = {16'($urandom_range(1, 4)), 16'($urandom_range(1, DEPTH))};
        step();
        control_rx_packet = '0;
        vectors++;
        if (data_rx_node_id !== snd || control_tx_packet !== 32'h0) begin
          miscompares++;
          $display("FAIL %s noise word %0d: rx_id=%h ctrl_tx=%h expected %h / 0", tag, i,
                   data_rx_node_id, control_tx_packet, snd);
        end
      end
      data_rx_packet = {snd, pay[i]};
      step();
      vectors++;
      if (i == n - 1) begin
        if (control_tx_packet !== {node_id, exp_len} || data_rx_node_id !== 16'h0) begin
          miscompares++;
          $display("FAIL %s announce: ctrl_tx=%h rx_id=%h expected %h / 0", tag,
                   control_tx_packet, data_rx_node_id, {node_id, exp_len});
        end
      end else if (data_rx_node_id !== snd || control_tx_packet !== 32'h0) begin
        miscompares++;
        $display("FAIL %s recv word %0d: rx_id=%h ctrl_tx=%h expected %h / 0", tag, i,
                 data_rx_node_id, control_tx_packet, snd);
      end
    end
    data_rx_packet = '0;
    x = '0;
    for (int k = 0; k < n; k++) begin
      step();
      t = pay[k] + node_id;
      x = x ^ t;
      vectors++;
      if (data_tx_packet !== {node_id, t} || control_tx_packet !== 32'h0) begin
        miscompares++;
        $display("FAIL %s send word %0d: data_tx=%h ctrl_tx=%h expected %h / 0", tag, k,
                 data_tx_packet, control_tx_packet, {node_id, t});
      end
    end
`ifdef COMPUTER_CHECKSUM_EN
    step();
    vectors++;
    if (data_tx_packet !== {node_id, x}) begin
      miscompares++;
      $display("FAIL %s checksum: data_tx=%h expected %h", tag, data_tx_packet, {node_id, x});
    end
`endif
    step();
    vectors++;
    if (data_tx_packet !== 32'h0 || control_tx_packet !== 32'h0 || data_rx_node_id !== 16'h0) begin
      miscompares++;
      $display("FAIL %s end: data_tx=%h ctrl_tx=%h rx_id=%h expected all 0", tag,
               data_tx_packet, control_tx_packet, data_rx_node_id);
    end
  endtask

  // Drive a control packet, then sender-matching words; nothing may be accepted.
  task automatic expect_ignored(input logic [31:0] ctrl, input string tag);
    control_rx_packet = ctrl;
    step();
    control_rx_packet = '0;
    for (int i = 0; i < 4; i++) begin
      data_rx_packet = {word_id_of(ctrl), 16'(i + 1)};
      step();
      vectors++;
      if (data_rx_node_id !== 16'h0 || control_tx_packet !== 32'h0 || data_tx_packet !== 32'h0) begin
        miscompares++;
        $display("FAIL %s cycle %0d: rx_id=%h ctrl_tx=%h data_tx=%h expected all 0", tag, i,
                 data_rx_node_id, control_tx_packet, data_tx_packet);
      end
    end
    data_rx_packet = '0;
  endtask

  function automatic logic [15:0] word_id_of(input logic [31:0] w);
    return w[31:16];
  endfunction

  task automatic test_reset();
    node_id = 16'd1;
    max_node = 16'd4;
    control_rx_packet = '0;
    data_rx_packet = 32'h0001000A;
    rst = 1'b1;
    step();
    step();
    vectors++;
    if (control_tx_packet !== 32'h0 || data_rx_node_id !== 16'h0 || data_tx_packet !== 32'h0) begin
      miscompares++;
      $display("FAIL reset: ctrl_tx=%h rx_id=%h data_tx=%h expected all 0",
               control_tx_packet, data_rx_node_id, data_tx_packet);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (control_tx_packet !== 32'h0 || data_rx_node_id !== 16'h0 || data_tx_packet !== 32'h0) begin
        miscompares++;
        $display("FAIL reset idle data %0d: ctrl_tx=%h rx_id=%h data_tx=%h expected all 0", i,
                 control_tx_packet, data_rx_node_id, data_tx_packet);
      end
    end
    data_rx_packet = '0;
  endtask

  task automatic test_basic();
    do_reset(16'd1, 16'd4);
    pay = '{16'h0005, 16'h000A, 16'h000B, 16'h000C, 16'h000D};
    run_burst(16'd1, 1'b0, "basic");
  endtask

  task automatic test_filtering();
    do_reset(16'd1, 16'd4);
    pay = '{16'h0005, 16'h000A, 16'h000B, 16'h000C, 16'h000D};
    run_burst(16'd1, 1'b1, "filter");
  endtask

  task automatic test_limits();
    do_reset(16'd1, 16'd4);
    expect_ignored(32'h00010000, "len0");
    expect_ignored({16'd1, 16'(DEPTH + 1)}, "len_over");
    expect_ignored(32'h00000005, "sender0");
    pay.delete();
    for (int i = 0; i < DEPTH; i++) pay.push_back(16'($urandom));
    run_burst(16'd2, 1'b1, "len_depth");
    pay = '{16'h1234};
    run_burst(16'd7, 1'b0, "len1");
  endtask

  task automatic test_bad_node();
    do_reset(16'd5, 16'd4);
    expect_ignored(32'h00010003, "node_gt_max");
    do_reset(16'd0, 16'd4);
    expect_ignored(32'h00010003, "node_zero");
  endtask

  task automatic test_wrap();
    do_reset(16'd3, 16'd4);
    pay = '{16'hFFFE, 16'hFFFD, 16'hFFFF};
    run_burst(16'd2, 1'b0, "wrap");
  endtask

  task automatic test_reset_mid();
    do_reset(16'd1, 16'd4);
    control_rx_packet = 32'h00010005;
    step();
    control_rx_packet = '0;
    data_rx_packet = 32'h00010011;
    step();
    data_rx_packet = 32'h00010022;
    step();
    data_rx_packet = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    vectors++;
    if (control_tx_packet !== 32'h0 || data_rx_node_id !== 16'h0 || data_tx_packet !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_mid: ctrl_tx=%h rx_id=%h data_tx=%h expected all 0",
               control_tx_packet, data_rx_node_id, data_tx_packet);
    end
    for (int i = 0; i < 3; i++) begin
      data_rx_packet = {16'd1, 16'(i)};
      step();
      vectors++;
      if (control_tx_packet !== 32'h0 || data_tx_packet !== 32'h0) begin
        miscompares++;
        $display("FAIL reset_mid tail %0d: ctrl_tx=%h data_tx=%h expected 0", i,
                 control_tx_packet, data_tx_packet);
      end
    end
    data_rx_packet = '0;
    pay = '{16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0500};
    run_burst(16'd1, 1'b0, "after_reset");
  endtask

  task automatic test_random();
    for (int b = 0; b < 12; b++) begin
      do_reset(16'($urandom_range(1, 8)), 16'd8);
      pay.delete();
      for (int i = 0; i < int'($urandom_range(1, DEPTH)); i++) pay.push_back(16'($urandom));
      run_burst(16'($urandom_range(1, 16'hFFFF)), 1'b1, "random");
    end
  endtask

  task automatic test_back_to_back();
    do_reset(16'd2, 16'd4);
    for (int b = 0; b < 3; b++) begin
      pay.delete();
      for (int i = 0; i < int'($urandom_range(1, 6)); i++) pay.push_back(16'($urandom));
      run_burst(16'(b + 1), 1'b0, "b2b");
    end
  endtask

  initial begin
    rst = 1'b1;
    node_id = '0;
    max_node = '0;
    control_rx_packet = '0;
    data_rx_packet = '0;
    test_reset();
    test_basic();
    test_filtering();
    test_limits();
    test_bad_node();
    test_wrap();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/computer.md
Name: computer

Overview:
- Network node endpoint for the photonic-interconnect processor array.
- Accepts a control packet announcing an incoming burst from a sender node, then captures that many data words into a local buffer.
- Applies a fixed per-word transform and re-transmits the burst under its own node id: a control announce word first, then the data words.
- Sits between the node's optical RX/TX interface and the rest of the node.

Parameters:
- DEPTH, 16, receive-buffer capacity in words (power of two, 2..256); maximum accepted burst length.

Ports:
- clk  in  1  system clock, all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- node_id  in  16  this node's id, 1..max_node, static after reset.
- max_node  in  16  highest node id in the network, static after reset.
- control_rx_packet  in  32  [31:16] sender id, [15:0] burst length; all-zero means idle.
- control_tx_packet  out  32  [31:16] node_id, [15:0] burst length; zero when not announcing.
- data_rx_node_id  out  16  sender id of the burst being received; 0 when not receiving.
- data_rx_packet  in  32  [31:16] sender id, [15:0] payload; sender id 0 means no word.
- data_tx_packet  out  32  [31:16] node_id, [15:0] transformed payload; zero when not sending.

Behaviour:
- Reset: state IDLE; all outputs 0; length, counters and buffer pointers 0. Buffer contents don't care. Reset mid-burst aborts the burst with no partial transmit.
- All outputs are registered.
- States: IDLE, RECV, ANNOUNCE, SEND.
- IDLE:
  - Sample control_rx_packet each edge.
  - Accept when sender != 0 and 1 <= length <= DEPTH: latch sender and length, set data_rx_node_id = sender, go to RECV.
  - length 0, length > DEPTH, or sender 0: ignore and stay in IDLE.
- RECV:
  - A data word is valid when data_rx_packet[31:16] == latched sender. Words from any other sender, including id 0, are ignored.
  - Each valid word: write payload to buffer[wr_ptr], increment wr_ptr.
  - On the edge accepting word number `length`: data_rx_node_id <= 0, control_tx_packet <= {node_id, length}, go to ANNOUNCE. control_tx is visible for exactly one cycle.
  - control_rx_packet is ignored in every state other than IDLE.
- ANNOUNCE:
  - Next edge: control_tx_packet <= 0, data_tx_packet <= {node_id, buffer[0] + node_id}, go to SEND.
- SEND:
  - One word per cycle, in order received. Transform: payload + node_id[15:0], mod 2^16 (wraps, no saturation).
  - After the last word has been held for one cycle: data_tx_packet <= 0, pointers cleared, return to IDLE.
  - A new control packet may be accepted on the same edge that IDLE is entered, but not earlier.
- Latency: control_tx asserts on the edge that captures the last data word. The first data_tx word appears one cycle later. Total transmit occupancy is 1 + length cycles (+1 with the feature below).
- Routing note: max_node is used only to validate node_id. If node_id == 0 or node_id > max_node, the node never accepts a burst (stays IDLE).

Optional Feature:
- Macro: COMPUTER_CHECKSUM_EN.
- When defined:
  - The announced length is length+1.
  - After the last data word, one extra data_tx word {node_id, XOR of all transformed payloads} is sent.
  - A burst with length == DEPTH is still accepted.
- When undefined: no checksum word; announced length equals the received length.

Decomposition:
- Package computer_pkg: state enum, field slice constants (ID_HI=31, ID_LO=16, LEN/PAYLOAD 15:0), and pack/unpack functions for the {id,value} 32-bit word.
- One sub-module, computer_rx_buffer: DEPTH x 16 synchronous-write, asynchronous-read register file with write pointer; read address driven by the SEND counter.

Test Plan:
- Reset: rst=1 for 2 cycles -> all outputs 0, state IDLE; no response to data_rx_packet=32'h0001000A.
- Basic burst, node_id=1, max_node=4: control_rx=32'h00010005 for one cycle, then data words 0005,000A,000B,000C,000D from sender 1.
  - data_rx_node_id=1 during RECV.
  - control_tx=32'h00010005 for one cycle.
  - Then data_tx 00010006, 0001000B, 0001000C, 0001000D, 0001000E; then all outputs 0.
- Filtering: data words with sender 2 or sender 0 interleaved mid-burst -> ignored; burst completes only after 5 sender-1 words.
- Length limits: control_rx=32'h00010000 -> ignored. control_rx={1, DEPTH+1} -> ignored. A second control during RECV -> ignored, first burst unaffected.
- Wrap: node_id=3, payload 16'hFFFE -> data_tx 32'h00030001.
- Reset mid-RECV after 2 of 5 words -> outputs 0, no announce. A fresh burst afterwards completes normally.
